bp_redirect_scheduler: RTL and testbench

Sits between the EX stage and the branch predictor. Buffers resolved-branch records in a small FIFO and drains them into the predictor's table-update port one per unstalled cycle. Detects mispredictions and exceptions/sret, and issues a registered redirect PC. Sequences a fixed-length pipeline flush during which wrong-path resolutions are refused.

---
 rtl/bp_redirect_scheduler_if.sv | 37 +++
 rtl/bp_redirect_scheduler.sv | 121 ++++++++++++
 tb/tb_bp_redirect_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bp_redirect_scheduler_if.sv
// Bus between EX and the redirect/update scheduler: resolution records, exception
// events, predictor update port and redirect/flush outputs.
interface bp_redirect_scheduler_if;
  logic        stall;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_pc;
  logic [31:0] res_target;
  logic [31:0] res_pred_pc;
  logic        res_branch;
  logic        res_predict;
  logic        res_actual;
  logic        excp_valid;
  logic        excp_sret;
  logic [31:0] excp_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_actual;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;

  modport slave (
    input  stall, res_valid, res_pc, res_target, res_pred_pc, res_branch,
           res_predict, res_actual, excp_valid, excp_sret, excp_pc,
    output res_ready, upd_valid, upd_pc, upd_actual, redirect_valid,
           redirect_pc, flush, busy
  );

  modport master (
    output stall, res_valid, res_pc, res_target, res_pred_pc, res_branch,
           res_predict, res_actual, excp_valid, excp_sret, excp_pc,
    input  res_ready, upd_valid, upd_pc, upd_actual, redirect_valid,
           redirect_pc, flush, busy
  );
endinterface

// File: rtl/bp_redirect_scheduler.sv
// Buffers resolved branches for predictor updates, detects mispredicts/exceptions,
// issues a registered redirect and holds a fixed-length flush window.
//
//   state    | meaning
//   ST_RUN   | accepting resolutions, redirect on mispredict/exception
//   ST_FLUSH | wrong-path squash; resolutions refused, FIFO keeps draining
module bp_redirect_scheduler #(
  parameter int          DEPTH_LOG2   = 2,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EXCP_ADDR    = 32'h1c09_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  bp_redirect_scheduler_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(FLUSH_CYCLES + 1);
  localparam int NW    = DEPTH_LOG2 + 1;

  localparam logic [0:0]            ST_RUN    = 1'b0;
  localparam logic [0:0]            ST_FLUSH  = 1'b1;
  localparam logic [NW-1:0]         CNT_ONE   = 1;
  localparam logic [NW-1:0]         CNT_FULL  = DEPTH;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
  localparam logic [CW-1:0]         FC_ONE    = 1;
  localparam logic [CW-1:0]         FC_RELOAD = FLUSH_CYCLES;

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         flush_cnt_q, flush_cnt_d;
  logic [NW-1:0]         count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]           mem_pc_q [DEPTH];
  logic [31:0]           mem_pc_d [DEPTH];
  logic                  mem_act_q [DEPTH];
  logic                  mem_act_d [DEPTH];
  logic [31:0]           sepc_q, sepc_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [31:0]           redirect_pc_q, redirect_pc_d;

  logic upd_valid, res_ready, accept, push, mispredict, redirect;

  assign upd_valid  = !bus.stall && (count_q != '0);
  // A full FIFO may still take a record when the head leaves in the same cycle.
  assign res_ready  = (state_q == ST_RUN) && ((count_q < CNT_FULL) || upd_valid);
  assign accept     = bus.res_valid && res_ready;
  assign push       = accept && bus.res_branch;
  assign mispredict = accept && ((bus.res_actual != bus.res_predict) ||
                                 (bus.res_pred_pc != bus.res_target));
  assign redirect   = bus.excp_valid || mispredict;

  always_comb begin
    mem_pc_d  = mem_pc_q;
    mem_act_d = mem_act_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      mem_pc_d[wr_ptr_q]  = bus.res_pc;
      mem_act_d[wr_ptr_q] = bus.res_actual;
      wr_ptr_d            = wr_ptr_q + PTR_ONE;
    end
    if (upd_valid) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !upd_valid)      count_d = count_q + CNT_ONE;
    else if (!push && upd_valid) count_d = count_q - CNT_ONE;
  end

  always_comb begin
    sepc_d           = sepc_q;
    redirect_valid_d = redirect;
    redirect_pc_d    = redirect_pc_q;
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    if (bus.excp_valid && !bus.excp_sret) sepc_d = bus.excp_pc + 32'd4;
    // Exception outranks a simultaneous mispredict; sret returns to the old sepc.
    if (bus.excp_valid)  redirect_pc_d = bus.excp_sret ? sepc_q : EXCP_ADDR;
    else if (mispredict) redirect_pc_d = bus.res_target;
    if (redirect) begin
      state_d     = ST_FLUSH;
      flush_cnt_d = FC_RELOAD;
    end else if (state_q == ST_FLUSH) begin
      flush_cnt_d = flush_cnt_q - FC_ONE;
      if (flush_cnt_q == FC_ONE) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_RUN;
      flush_cnt_q      <= '0;
      count_q          <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      sepc_q           <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      count_q          <= count_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      sepc_q           <= sepc_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_pc_q  <= mem_pc_d;
    mem_act_q <= mem_act_d;
  end

  assign bus.res_ready      = res_ready;
  assign bus.upd_valid      = upd_valid;
  assign bus.upd_pc         = mem_pc_q[rd_ptr_q];
  assign bus.upd_actual     = mem_act_q[rd_ptr_q];
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = (state_q == ST_FLUSH);
  assign bus.busy           = (state_q == ST_FLUSH);
endmodule

// File: tb/tb_bp_redirect_scheduler.sv
// Directed bench for bp_redirect_scheduler with hand-computed expectations.
module tb_bp_redirect_scheduler;
  localparam logic [31:0] EXCP = 32'h1c09_0000;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  bp_redirect_scheduler_if bif();

  bp_redirect_scheduler #(
    .DEPTH_LOG2(2), .FLUSH_CYCLES(2), .EXCP_ADDR(EXCP)
  ) dut (
    .clk(clk), .rst(rst), .bus(bif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.res_valid  = 1'b0;
    bif.excp_valid = 1'b0;
    bif.excp_sret  = 1'b0;
  endtask

  task automatic set_res(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] pred_pc, input logic pred, input logic act);
    bif.res_valid   = 1'b1;
    bif.res_branch  = 1'b1;
    bif.res_pc      = pc;
    bif.res_target  = tgt;
    bif.res_pred_pc = pred_pc;
    bif.res_predict = pred;
    bif.res_actual  = act;
  endtask

  initial begin
    rst = 1'b1;
    bif.stall = 1'b0;
    bif.res_pc = '0; bif.res_target = '0; bif.res_pred_pc = '0;
    bif.res_branch = 1'b0; bif.res_predict = 1'b0; bif.res_actual = 1'b0;
    bif.excp_pc = '0;
    idle();
    cyc(); cyc();
    check("rst_redirect_valid", 32'(bif.redirect_valid), 0);
    check("rst_redirect_pc", bif.redirect_pc, 0);
    check("rst_flush", 32'(bif.flush), 0);
    check("rst_busy", 32'(bif.busy), 0);
    check("rst_upd_valid", 32'(bif.upd_valid), 0);
    check("rst_res_ready", 32'(bif.res_ready), 1);
    rst = 1'b0;
    cyc();

    // Correctly predicted taken branch.
    set_res(32'h100, 32'h140, 32'h140, 1'b1, 1'b1);
    #1 check("ok_ready", 32'(bif.res_ready), 1);
    cyc(); idle();
    check("ok_no_redirect", 32'(bif.redirect_valid), 0);
    check("ok_upd_valid", 32'(bif.upd_valid), 1);
    check("ok_upd_pc", bif.upd_pc, 32'h100);
    check("ok_upd_actual", 32'(bif.upd_actual), 1);
    cyc();
    check("ok_drained", 32'(bif.upd_valid), 0);

    // Direction mispredict.
    set_res(32'h200, 32'h280, 32'h204, 1'b0, 1'b1);
    cyc(); idle();
    check("mp_redirect_valid", 32'(bif.redirect_valid), 1);
    check("mp_redirect_pc", bif.redirect_pc, 32'h280);
    check("mp_flush1", 32'(bif.flush), 1);
    check("mp_busy1", 32'(bif.busy), 1);
    check("mp_ready1", 32'(bif.res_ready), 0);
    check("mp_upd_valid", 32'(bif.upd_valid), 1);
    check("mp_upd_pc", bif.upd_pc, 32'h200);
    cyc();
    check("mp_pulse_end", 32'(bif.redirect_valid), 0);
    check("mp_flush2", 32'(bif.flush), 1);
    check("mp_ready2", 32'(bif.res_ready), 0);
    cyc();
    check("mp_flush_end", 32'(bif.flush), 0);
    check("mp_busy_end", 32'(bif.busy), 0);
    check("mp_ready_back", 32'(bif.res_ready), 1);

    // Fill under stall, drain in order.
    bif.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_res(32'h400 + 32'(4 * i), 32'h900, 32'h900, i[0], i[0]);
      cyc();
    end
    idle();
    check("full_ready", 32'(bif.res_ready), 0);
    check("full_stall_upd", 32'(bif.upd_valid), 0);
    bif.stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_valid", 32'(bif.upd_valid), 1);
      check("drain_pc", bif.upd_pc, 32'h400 + 32'(4 * i));
      check("drain_actual", 32'(bif.upd_actual), 32'(i[0]));
      cyc();
    end
    check("drain_empty", 32'(bif.upd_valid), 0);

    // Refill, then push and pop together while full.
    bif.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_res(32'h500 + 32'(4 * i), 32'h900, 32'h900, 1'b1, 1'b1);
      cyc();
    end
    bif.stall = 1'b0;
    set_res(32'h510, 32'h900, 32'h900, 1'b0, 1'b0);
    #1;
    check("pp_ready_full", 32'(bif.res_ready), 1);
    check("pp_head", bif.upd_pc, 32'h500);
    cyc(); idle();
    for (int i = 1; i < 5; i++) begin
      #1;
      check("pp_drain_pc", bif.upd_pc, 32'h500 + 32'(4 * i));
      check("pp_drain_valid", 32'(bif.upd_valid), 1);
      cyc();
    end
    check("pp_empty", 32'(bif.upd_valid), 0);

    // ecall then sret.
    bif.excp_valid = 1'b1; bif.excp_sret = 1'b0; bif.excp_pc = 32'h300;
    cyc(); idle();
    check("ecall_valid", 32'(bif.redirect_valid), 1);
    check("ecall_pc", bif.redirect_pc, EXCP);
    cyc(); cyc();
    bif.excp_valid = 1'b1; bif.excp_sret = 1'b1;
    cyc(); idle();
    check("sret_valid", 32'(bif.redirect_valid), 1);
    check("sret_pc", bif.redirect_pc, 32'h304);
    cyc(); cyc();

    // Exception beats a simultaneous mispredict; record still enqueued.
    bif.excp_valid = 1'b1; bif.excp_sret = 1'b0; bif.excp_pc = 32'h600;
    set_res(32'h700, 32'h780, 32'h704, 1'b0, 1'b1);
    cyc(); idle();
    check("both_pc", bif.redirect_pc, EXCP);
    check("both_upd_pc", bif.upd_pc, 32'h700);
    check("both_upd_valid", 32'(bif.upd_valid), 1);
    // Exception inside the flush window restarts it.
    bif.excp_valid = 1'b1; bif.excp_pc = 32'h610;
    cyc(); idle();
    check("reload_valid", 32'(bif.redirect_valid), 1);
    check("reload_flush1", 32'(bif.flush), 1);
    cyc();
    check("reload_flush2", 32'(bif.flush), 1);
    cyc();
    check("reload_flush_end", 32'(bif.flush), 0);

    // Reset with three entries queued and a flush in progress.
    bif.stall = 1'b1;
    set_res(32'h800, 32'h900, 32'h900, 1'b1, 1'b1); cyc();
    set_res(32'h804, 32'h900, 32'h900, 1'b1, 1'b1); cyc();
    set_res(32'h808, 32'h880, 32'h80c, 1'b0, 1'b1); cyc();
    idle();
    check("pre_rst_busy", 32'(bif.busy), 1);
    rst = 1'b1;
    cyc();
    bif.stall = 1'b0;
    #1;
    check("rst2_busy", 32'(bif.busy), 0);
    check("rst2_flush", 32'(bif.flush), 0);
    check("rst2_upd_valid", 32'(bif.upd_valid), 0);
    check("rst2_ready", 32'(bif.res_ready), 1);
    check("rst2_redirect", 32'(bif.redirect_valid), 0);
    rst = 1'b0;
    cyc();
    check("rst2_no_stale", 32'(bif.upd_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
